// File: rtl/serial_match_accumulator_if.sv
// rtl/serial_match_accumulator_if.sv - handshake and result bundle for the serial match accumulator
interface serial_match_accumulator_if #(
    parameter int WIDTH = 8
) ();
    localparam int CW = $clog2(WIDTH + 1);

    logic          start;
    logic          match_bit;
    logic          match_valid;
    logic          busy;
    logic          done;
    logic          equal;
    logic [CW-1:0] mismatch_count;
    logic [CW-1:0] first_mismatch_idx;

    modport master (
        output start, match_bit, match_valid,
        input  busy, done, equal, mismatch_count, first_mismatch_idx
    );

    modport slave (
        input  start, match_bit, match_valid,
        output busy, done, equal, mismatch_count, first_mismatch_idx
    );
endinterface

// File: rtl/serial_match_accumulator.sv
// rtl/serial_match_accumulator.sv - accumulates one XNOR result bit per clock into a word-equality verdict
module serial_match_accumulator #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    serial_match_accumulator_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] IDX_NONE = CW'(WIDTH);
    localparam logic [CW-1:0] IDX_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] idx;
    logic [CW-1:0] mm_count;
    logic [CW-1:0] mm_count_next;
    logic [CW-1:0] first_idx;
    logic          equal_q;
    logic          busy_c;
    logic          done_c;
    logic          accept;
    logic          load;
    logic          last;

    // Qualify start and bit acceptance by state; start always wins over match_valid in IDLE
    assign load          = (state == IDLE) && bus.start;
    assign accept        = (state == RUN) && bus.match_valid;
    assign last          = (idx == IDX_LAST);
    assign mm_count_next = bus.match_bit ? mm_count : (mm_count + ONE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status decode; DONE is a single-cycle state
    always_comb begin
        state_next = state;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy_c = 1'b1;
                if (accept && last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done_c     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Bit index, mismatch tally, first-mismatch capture and registered equality verdict
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            mm_count  <= '0;
            first_idx <= '0;
            equal_q   <= 1'b0;
        end else if (load) begin
            idx       <= '0;
            mm_count  <= '0;
            first_idx <= IDX_NONE;
            equal_q   <= 1'b0;
        end else if (accept) begin
            idx      <= idx + ONE;
            mm_count <= mm_count_next;
            if (!bus.match_bit && (first_idx == IDX_NONE)) begin
                first_idx <= idx;
            end
            if (last) begin
                equal_q <= (mm_count_next == '0);
            end
        end
    end

    assign bus.busy               = busy_c;
    assign bus.done               = done_c;
    assign bus.equal              = equal_q;
    assign bus.mismatch_count     = mm_count;
    assign bus.first_mismatch_idx = first_idx;
endmodule

// File: tb/tb_serial_match_accumulator.sv
// tb/tb_serial_match_accumulator.sv - directed bench for serial_match_accumulator
module tb_serial_match_accumulator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    serial_match_accumulator_if #(.WIDTH(8)) bus ();

    serial_match_accumulator #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_word(input logic [0:7] bits, input int stall_at, input int stall_len,
                            input bit poke_start, output int cycles);
        cycles = 0;
        bus.start       = 1'b1;
        bus.match_valid = 1'b1;
        bus.match_bit   = 1'b0;
        tick();
        bus.start       = 1'b0;
        bus.match_valid = 1'b0;
        vectors++;
        if (bus.busy !== 1'b1 || bus.mismatch_count !== 4'd0 || bus.first_mismatch_idx !== 4'd8 || bus.equal !== 1'b0) begin
            miscompares++;
            $display("FAIL start_clear: busy=%b cnt=%0d first=%0d eq=%b, want busy=1 cnt=0 first=8 eq=0",
                     bus.busy, bus.mismatch_count, bus.first_mismatch_idx, bus.equal);
        end
        for (int i = 0; i < 8; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    bus.match_valid = 1'b0;
                    bus.match_bit   = 1'b0;
                    tick();
                    cycles++;
                end
            end
            bus.match_valid = 1'b1;
            bus.match_bit   = bits[i];
            bus.start       = poke_start && (i == 3);
            tick();
            cycles++;
            if (i < 7) begin
                vectors++;
                if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL run_status bit %0d: done=%b busy=%b, want done=0 busy=1", i, bus.done, bus.busy);
                end
            end
        end
        bus.match_valid = 1'b0;
        bus.start       = poke_start;
        vectors++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse: done=%b busy=%b, want done=1 busy=0", bus.done, bus.busy);
        end
        tick();
        bus.start = 1'b0;
        vectors++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL done_one_cycle: done=%b busy=%b, want done=0 busy=0", bus.done, bus.busy);
        end
    endtask

    task automatic test_reset();
        bus.start       = 1'b0;
        bus.match_valid = 1'b1;
        bus.match_bit   = 1'b0;
        rst_n           = 1'b0;
        tick();
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.equal !== 1'b0 ||
            bus.mismatch_count !== 4'd0 || bus.first_mismatch_idx !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b done=%b eq=%b cnt=%0d first=%0d, want all 0",
                     bus.busy, bus.done, bus.equal, bus.mismatch_count, bus.first_mismatch_idx);
        end
        #2 rst_n = 1'b1;
        tick();
        tick();
        vectors++;
        if (bus.busy !== 1'b0 || bus.mismatch_count !== 4'd0 || bus.first_mismatch_idx !== 4'd0) begin
            miscompares++;
            $display("FAIL idle_ignores_valid: busy=%b cnt=%0d first=%0d, want busy=0 cnt=0 first=0",
                     bus.busy, bus.mismatch_count, bus.first_mismatch_idx);
        end
        bus.match_valid = 1'b0;
    endtask

    task automatic test_all_match();
        int cycles;
        run_word(8'b11111111, -1, 0, 1'b0, cycles);
        vectors++;
        if (cycles !== 8) begin
            miscompares++;
            $display("FAIL all_match_latency: cycles=%0d, want 8", cycles);
        end
        vectors++;
        if (bus.equal !== 1'b1 || bus.mismatch_count !== 4'd0 || bus.first_mismatch_idx !== 4'd8) begin
            miscompares++;
            $display("FAIL all_match_result: eq=%b cnt=%0d first=%0d, want eq=1 cnt=0 first=8",
                     bus.equal, bus.mismatch_count, bus.first_mismatch_idx);
        end
    endtask

    task automatic test_mixed();
        int cycles;
        run_word(8'b11010111, -1, 0, 1'b0, cycles);
        vectors++;
        if (bus.equal !== 1'b0 || bus.mismatch_count !== 4'd2 || bus.first_mismatch_idx !== 4'd2) begin
            miscompares++;
            $display("FAIL mixed_result: eq=%b cnt=%0d first=%0d, want eq=0 cnt=2 first=2",
                     bus.equal, bus.mismatch_count, bus.first_mismatch_idx);
        end
    endtask

    task automatic test_stall();
        int cycles;
        run_word(8'b11111111, 4, 3, 1'b0, cycles);
        vectors++;
        if (cycles !== 11) begin
            miscompares++;
            $display("FAIL stall_latency: cycles=%0d, want 11", cycles);
        end
        vectors++;
        if (bus.equal !== 1'b1 || bus.mismatch_count !== 4'd0 || bus.first_mismatch_idx !== 4'd8) begin
            miscompares++;
            $display("FAIL stall_result: eq=%b cnt=%0d first=%0d, want eq=1 cnt=0 first=8",
                     bus.equal, bus.mismatch_count, bus.first_mismatch_idx);
        end
    endtask

    task automatic test_reset_mid_word();
        int cycles;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.match_valid = 1'b1;
            bus.match_bit   = 1'b0;
            tick();
        end
        bus.match_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.equal !== 1'b0 ||
            bus.mismatch_count !== 4'd0 || bus.first_mismatch_idx !== 4'd0) begin
            miscompares++;
            $display("FAIL async_reset: busy=%b done=%b eq=%b cnt=%0d first=%0d, want all 0",
                     bus.busy, bus.done, bus.equal, bus.mismatch_count, bus.first_mismatch_idx);
        end
        tick();
        #2 rst_n = 1'b1;
        tick();
        run_word(8'b11111111, -1, 0, 1'b0, cycles);
        vectors++;
        if (bus.equal !== 1'b1 || bus.mismatch_count !== 4'd0 || bus.first_mismatch_idx !== 4'd8 || cycles !== 8) begin
            miscompares++;
            $display("FAIL post_reset_word: eq=%b cnt=%0d first=%0d cycles=%0d, want eq=1 cnt=0 first=8 cycles=8",
                     bus.equal, bus.mismatch_count, bus.first_mismatch_idx, cycles);
        end
    endtask

    task automatic test_ignored_start();
        int cycles;
        run_word(8'b01111110, -1, 0, 1'b1, cycles);
        vectors++;
        if (cycles !== 8 || bus.equal !== 1'b0 || bus.mismatch_count !== 4'd2 || bus.first_mismatch_idx !== 4'd0) begin
            miscompares++;
            $display("FAIL poked_word: cycles=%0d eq=%b cnt=%0d first=%0d, want cycles=8 eq=0 cnt=2 first=0",
                     cycles, bus.equal, bus.mismatch_count, bus.first_mismatch_idx);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.equal !== 1'b0 ||
                bus.mismatch_count !== 4'd2 || bus.first_mismatch_idx !== 4'd0) begin
                miscompares++;
                $display("FAIL idle_hold %0d: busy=%b done=%b eq=%b cnt=%0d first=%0d, want busy=0 done=0 eq=0 cnt=2 first=0",
                         k, bus.busy, bus.done, bus.equal, bus.mismatch_count, bus.first_mismatch_idx);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cycles;
        run_word(8'b00000000, -1, 0, 1'b0, cycles);
        vectors++;
        if (bus.equal !== 1'b0 || bus.mismatch_count !== 4'd8 || bus.first_mismatch_idx !== 4'd0) begin
            miscompares++;
            $display("FAIL all_zero_result: eq=%b cnt=%0d first=%0d, want eq=0 cnt=8 first=0",
                     bus.equal, bus.mismatch_count, bus.first_mismatch_idx);
        end
        run_word(8'b10111111, -1, 0, 1'b0, cycles);
        vectors++;
        if (cycles !== 8 || bus.equal !== 1'b0 || bus.mismatch_count !== 4'd1 || bus.first_mismatch_idx !== 4'd1) begin
            miscompares++;
            $display("FAIL back_to_back_result: cycles=%0d eq=%b cnt=%0d first=%0d, want cycles=8 eq=0 cnt=1 first=1",
                     cycles, bus.equal, bus.mismatch_count, bus.first_mismatch_idx);
        end
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.match_valid = 1'b0;
        bus.match_bit   = 1'b0;
        test_reset();
        test_all_match();
        test_mixed();
        test_stall();
        test_reset_mid_word();
        test_ignored_start();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
